// File: rtl/grid_pkg.sv
// Shared definitions for the paper-roll grid pipeline: character codes,
// loader state encoding and error codes.
package grid_pkg;

   localparam logic [7:0] CH_PAPER = 8'h40;
   localparam logic [7:0] CH_EMPTY = 8'h2E;
   localparam logic [7:0] CH_LF    = 8'h0A;
   localparam logic [7:0] CH_CR    = 8'h0D;

   typedef enum logic [1:0] {
      ST_LOAD,
      ST_DONE,
      ST_ERR
   } state_e;

   localparam logic [1:0] ERR_NONE     = 2'd0;
   localparam logic [1:0] ERR_BAD_CHAR = 2'd1;
   localparam logic [1:0] ERR_COL_OVF  = 2'd2;
   localparam logic [1:0] ERR_ROW_OVF  = 2'd3;

endpackage

// File: rtl/grid_char_decode.sv
// Combinational classifier for one puzzle byte.
module grid_char_decode
   import grid_pkg::*;
(
   input  logic [7:0] ch,
   output logic       is_paper,
   output logic       is_empty,
   output logic       is_lf,
   output logic       is_cr,
   output logic       is_bad
);

   // Exactly one class flag is raised for every byte value.
   always_comb begin
      is_paper = 1'b0;
      is_empty = 1'b0;
      is_lf    = 1'b0;
      is_cr    = 1'b0;
      is_bad   = 1'b0;
      case (ch)
         CH_PAPER: is_paper = 1'b1;
         CH_EMPTY: is_empty = 1'b1;
         CH_LF:    is_lf    = 1'b1;
         CH_CR:    is_cr    = 1'b1;
         default:  is_bad   = 1'b1;
      endcase
   end

endmodule

// File: rtl/grid_loader.sv
// Byte-stream to bit-matrix loader with roll counting, valid/ready grid
// hand-off and a sticky error trap for malformed input.
module grid_loader
   import grid_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int DEPTH = 16
) (
   input  logic                                clk,
   input  logic                                rst,
   input  logic                                in_valid,
   input  logic [7:0]                          in_data,
   input  logic                                in_last,
   output logic                                in_ready,
   output logic [DEPTH-1:0][WIDTH-1:0]         grid,
   output logic                                grid_valid,
   input  logic                                grid_ready,
   output logic [$clog2(WIDTH*DEPTH+1)-1:0]    paper_count,
   output logic [$clog2(DEPTH+1)-1:0]          rows_loaded,
   output logic                                err,
   output logic [1:0]                          err_code
);

   localparam int PCW = $clog2(WIDTH*DEPTH+1);
   localparam int RIW = $clog2(DEPTH+1);
   localparam int CIW = $clog2(WIDTH+1);
   localparam int RSW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CSW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [RIW-1:0] ROW_MAX = RIW'(DEPTH);
   localparam logic [CIW-1:0] COL_MAX = CIW'(WIDTH);

   state_e                      state_q, state_d;
   logic [RIW-1:0]              row_q, row_d;
   logic [CIW-1:0]              col_q, col_d;
   logic [DEPTH-1:0][WIDTH-1:0] grid_q, grid_d;
   logic [PCW-1:0]              count_q, count_d;
   logic [RIW-1:0]              rows_q, rows_d;
   logic [1:0]                  code_q, code_d;

   logic is_paper, is_empty, is_lf, is_cr, is_bad;
   logic is_cell;
   logic [RSW-1:0] row_sel;
   logic [CSW-1:0] col_sel;

   grid_char_decode u_decode (
      .ch       (in_data),
      .is_paper (is_paper),
      .is_empty (is_empty),
      .is_lf    (is_lf),
      .is_cr    (is_cr),
      .is_bad   (is_bad)
   );

   assign is_cell = is_paper | is_empty;
   // Indices are only used for writing once bounds are confirmed, so the
   // truncated selects are always in range.
   assign row_sel = row_q[RSW-1:0];
   assign col_sel = col_q[CSW-1:0];

   // State and datapath registers; reset discards any partial load.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_LOAD;
         row_q   <= '0;
         col_q   <= '0;
         grid_q  <= '0;
         count_q <= '0;
         rows_q  <= '0;
         code_q  <= ERR_NONE;
      end else begin
         state_q <= state_d;
         row_q   <= row_d;
         col_q   <= col_d;
         grid_q  <= grid_d;
         count_q <= count_d;
         rows_q  <= rows_d;
         code_q  <= code_d;
      end
   end

   // Next-state and datapath update for byte decode, hand-off and error trap.
   always_comb begin
      state_d = state_q;
      row_d   = row_q;
      col_d   = col_q;
      grid_d  = grid_q;
      count_d = count_q;
      rows_d  = rows_q;
      code_d  = code_q;
      case (state_q)
         ST_LOAD: begin
            if (in_valid) begin
               if (is_bad) begin
                  state_d = ST_ERR;
                  code_d  = ERR_BAD_CHAR;
               end else if (is_cell && row_q == ROW_MAX) begin
                  state_d = ST_ERR;
                  code_d  = ERR_ROW_OVF;
               end else if (is_cell && col_q == COL_MAX) begin
                  state_d = ST_ERR;
                  code_d  = ERR_COL_OVF;
               end else begin
                  if (is_cell) begin
                     if (is_paper) begin
                        grid_d[row_sel][col_sel] = 1'b1;
                        count_d = count_q + PCW'(1);
                     end
                     col_d = col_q + CIW'(1);
                  end else if (is_lf && col_q != '0) begin
                     row_d = row_q + RIW'(1);
                     col_d = '0;
                  end
                  // rows_loaded counts a trailing partial row as well.
                  if (in_last) begin
                     state_d = ST_DONE;
                     rows_d  = row_d + RIW'(col_d != '0);
                  end
               end
            end
         end
         ST_DONE: begin
            if (grid_ready) begin
               state_d = ST_LOAD;
               row_d   = '0;
               col_d   = '0;
               grid_d  = '0;
               count_d = '0;
               rows_d  = '0;
            end
         end
         ST_ERR: begin
            state_d = ST_ERR;
         end
         default: begin
            state_d = ST_LOAD;
         end
      endcase
   end

   assign in_ready    = (state_q == ST_LOAD);
   assign grid_valid  = (state_q == ST_DONE);
   assign err         = (state_q == ST_ERR);
   assign err_code    = code_q;
   assign grid        = grid_q;
   assign paper_count = count_q;
   assign rows_loaded = rows_q;

endmodule
